// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-bit positions, MEM-stage FSM encoding
// and the default data-bus timeout.
package mips_pkg;

    localparam int CTLM_BRANCH    = 2;
    localparam int CTLM_MEMREAD   = 1;
    localparam int CTLM_MEMWRITE  = 0;

    localparam int CTLWB_REGWRITE = 1;
    localparam int CTLWB_MEMTOREG = 0;

    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [0:0] {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_wb.sv
// MEM/WB pipeline register. A bubble clears the control field and leaves the
// data fields holding; load data only updates when a read actually completed.
module mem_wb
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble_i,
    input  logic        load_data_i,
    input  logic [1:0]  ctlwb_i,
    input  logic [31:0] alu_out_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] rdata_i,
    output logic [1:0]  ctlwb_o,
    output logic [31:0] alu_out_o,
    output logic [4:0]  rd_o,
    output logic [31:0] rdata_o
);

    logic [1:0]  ctlwb_q;
    logic [31:0] alu_out_q;
    logic [4:0]  rd_q;
    logic [31:0] rdata_q;

    // Pipeline register update with bubble insertion
    always_ff @(posedge clk) begin
        if (rst) begin
            ctlwb_q   <= 2'b00;
            alu_out_q <= 32'h0000_0000;
            rd_q      <= 5'd0;
            rdata_q   <= 32'h0000_0000;
        end else if (bubble_i) begin
            ctlwb_q   <= 2'b00;
        end else begin
            ctlwb_q   <= ctlwb_i;
            alu_out_q <= alu_out_i;
            rd_q      <= rd_i;
            if (load_data_i) begin
                rdata_q <= rdata_i;
            end
        end
    end

    assign ctlwb_o   = ctlwb_q;
    assign alu_out_o = alu_out_q;
    assign rd_o      = rd_q;
    assign rdata_o   = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: branch resolution, data-memory req/ack handshake with a bounded
// wait, upstream stall generation, fault flagging and the MEM/WB register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MEM_bpc,
    input  logic [31:0] MEM_alu_out,
    input  logic [31:0] MEM_rd2,
    input  logic [1:0]  MEM_ctlwb,
    input  logic [2:0]  MEM_ctlm,
    input  logic        MEM_alu_zero,
    input  logic [4:0]  MEM_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        mem_fault,
    output logic [1:0]  WB_ctlwb,
    output logic [31:0] WB_read_data,
    output logic [31:0] WB_alu_out,
    output logic [4:0]  WB_rd
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic             bubble_s;
    logic             load_data_s;
    logic             access_s;
    logic             aligned_s;
    logic             is_read_s;

    assign access_s   = MEM_ctlm[CTLM_MEMREAD] | MEM_ctlm[CTLM_MEMWRITE];
    assign aligned_s  = (MEM_alu_out[1:0] == 2'b00);
    // A write wins when both strobes are set, so only a pure read returns data.
    assign is_read_s  = MEM_ctlm[CTLM_MEMREAD] & ~MEM_ctlm[CTLM_MEMWRITE];

    assign dmem_we       = MEM_ctlm[CTLM_MEMWRITE];
    assign dmem_addr     = MEM_alu_out;
    assign dmem_wdata    = MEM_rd2;
    assign pc_src        = MEM_ctlm[CTLM_BRANCH] & MEM_alu_zero;
    assign branch_target = MEM_bpc;
    assign mem_fault     = fault_q;

    // Access FSM: next state, wait counter, request/stall and WB control
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dmem_req    = 1'b0;
        mem_stall   = 1'b0;
        fault_d     = 1'b0;
        bubble_s    = 1'b0;
        load_data_s = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (access_s && aligned_s) begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        load_data_s = is_read_s;
                    end else begin
                        mem_stall = 1'b1;
                        bubble_s  = 1'b1;
                        state_d   = MEM_WAIT;
                        cnt_d     = CNT_W'(1);
                    end
                end else if (access_s) begin
                    fault_d  = 1'b1;
                    bubble_s = 1'b1;
                end else begin
                    cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                // The final budgeted cycle drops the request, so an ack then is ignored.
                if (cnt_q == TIMEOUT_C) begin
                    fault_d  = 1'b1;
                    bubble_s = 1'b1;
                    state_d  = MEM_IDLE;
                    cnt_d    = '0;
                end else if (dmem_ack) begin
                    dmem_req    = 1'b1;
                    load_data_s = is_read_s;
                    state_d     = MEM_IDLE;
                    cnt_d       = '0;
                end else begin
                    dmem_req  = 1'b1;
                    mem_stall = 1'b1;
                    bubble_s  = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = MEM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, wait counter and fault pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    mem_wb u_mem_wb (
        .clk         (clk),
        .rst         (rst),
        .bubble_i    (bubble_s),
        .load_data_i (load_data_s),
        .ctlwb_i     (MEM_ctlwb),
        .alu_out_i   (MEM_alu_out),
        .rd_i        (MEM_rd),
        .rdata_i     (dmem_rdata),
        .ctlwb_o     (WB_ctlwb),
        .alu_out_o   (WB_alu_out),
        .rd_o        (WB_rd),
        .rdata_o     (WB_read_data)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: single-cycle vector table plus hand-written
// wait-state, timeout and reset sequences, with WB results scored from a queue.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] MEM_bpc, MEM_alu_out, MEM_rd2, dmem_rdata;
    logic [1:0]  MEM_ctlwb;
    logic [2:0]  MEM_ctlm;
    logic        MEM_alu_zero, dmem_ack;
    logic [4:0]  MEM_rd;
    logic        dmem_req, dmem_we, mem_stall, pc_src, mem_fault;
    logic [31:0] dmem_addr, dmem_wdata, branch_target, WB_read_data, WB_alu_out;
    logic [1:0]  WB_ctlwb;
    logic [4:0]  WB_rd;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_rdata;

    typedef struct {
        logic [2:0]  ctlm;
        logic [1:0]  ctlwb;
        logic        zero;
        logic [31:0] addr;
        logic [31:0] rd2;
        logic [31:0] bpc;
        logic [4:0]  rd;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic        e_pc;
        logic        e_fault;
        logic [1:0]  e_ctlwb;
        logic        e_full;
        logic [31:0] e_rdata;
    } vec_t;

    typedef struct {
        logic        full;
        logic [1:0]  ctlwb;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] rdata;
    } sb_t;

    sb_t  sbq[$];
    vec_t vecs[10];

    mem_stage #(.TIMEOUT(8), .CNT_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .MEM_bpc       (MEM_bpc),
        .MEM_alu_out   (MEM_alu_out),
        .MEM_rd2       (MEM_rd2),
        .MEM_ctlwb     (MEM_ctlwb),
        .MEM_ctlm      (MEM_ctlm),
        .MEM_alu_zero  (MEM_alu_zero),
        .MEM_rd        (MEM_rd),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .mem_stall     (mem_stall),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .mem_fault     (mem_fault),
        .WB_ctlwb      (WB_ctlwb),
        .WB_read_data  (WB_read_data),
        .WB_alu_out    (WB_alu_out),
        .WB_rd         (WB_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drv(input logic [2:0] ctlm, input logic [1:0] ctlwb, input logic zero,
                       input logic [31:0] addr, input logic [31:0] rd2, input logic [31:0] bpc,
                       input logic [4:0] rd, input logic ack, input logic [31:0] rdata);
        MEM_ctlm     = ctlm;
        MEM_ctlwb    = ctlwb;
        MEM_alu_zero = zero;
        MEM_alu_out  = addr;
        MEM_rd2      = rd2;
        MEM_bpc      = bpc;
        MEM_rd       = rd;
        dmem_ack     = ack;
        dmem_rdata   = rdata;
    endtask

    task automatic push(input logic full, input logic [1:0] ctlwb, input logic [31:0] alu,
                        input logic [4:0] rd, input logic [31:0] rdata);
        sb_t e;
        e.full  = full;
        e.ctlwb = ctlwb;
        e.alu   = alu;
        e.rd    = rd;
        e.rdata = rdata;
        sbq.push_back(e);
    endtask

    // Advance one clock, then score the WB register and the fault pulse.
    task automatic tick(input logic e_fault);
        sb_t e;
        @(posedge clk);
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("wb_ctlwb", {30'd0, WB_ctlwb}, {30'd0, e.ctlwb});
            if (e.full) begin
                chk("wb_alu_out", WB_alu_out, e.alu);
                chk("wb_rd", {27'd0, WB_rd}, {27'd0, e.rd});
                chk("wb_read_data", WB_read_data, e.rdata);
            end
        end
        chk("mem_fault", {31'd0, mem_fault}, {31'd0, e_fault});
    endtask

    // One access that completes after n_wait stall cycles.
    task automatic run_acc(input string nm, input logic [2:0] ctlm, input logic [1:0] ctlwb,
                           input logic [31:0] addr, input logic [31:0] rd2, input logic [4:0] rd,
                           input int n_wait, input logic [31:0] rdata);
        for (int k = 0; k <= n_wait; k++) begin
            drv(ctlm, ctlwb, 1'b0, addr, rd2, 32'h0, rd, (k == n_wait), rdata);
            #1;
            chk({nm, "_req"}, {31'd0, dmem_req}, 32'd1);
            chk({nm, "_we"}, {31'd0, dmem_we}, {31'd0, ctlm[0]});
            chk({nm, "_addr"}, dmem_addr, addr);
            chk({nm, "_wdata"}, dmem_wdata, rd2);
            chk({nm, "_stall"}, {31'd0, mem_stall}, {31'd0, (k < n_wait)});
            if (k < n_wait) begin
                push(1'b0, 2'b00, 32'h0, 5'd0, 32'h0);
            end else begin
                if (ctlm == 3'b010) exp_rdata = rdata;
                push(1'b1, ctlwb, addr, rd, exp_rdata);
            end
            tick(1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'b000, 2'b10, 1'b0, 32'h1111_0000, 32'h0, 32'h0, 5'd5, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 32'h0};
        vecs[1] = '{3'b010, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 5'd7, 1'b1, 32'hDEADBEEF,
                    1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{3'b100, 2'b00, 1'b1, 32'h0, 32'h0, 32'h40, 5'd0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'hDEADBEEF};
        vecs[3] = '{3'b100, 2'b00, 1'b0, 32'h0, 32'h0, 32'h80, 5'd0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'hDEADBEEF};
        vecs[4] = '{3'b001, 2'b00, 1'b0, 32'h24, 32'h55, 32'h0, 5'd3, 1'b1, 32'h0000FFFF,
                    1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'hDEADBEEF};
        vecs[5] = '{3'b010, 2'b11, 1'b0, 32'h13, 32'h0, 32'h0, 5'd8, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'hDEADBEEF};
        vecs[6] = '{3'b000, 2'b10, 1'b0, 32'h2222, 32'h0, 32'h0, 5'd4, 1'b1, 32'h00000BAD,
                    1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 32'hDEADBEEF};
        vecs[7] = '{3'b011, 2'b00, 1'b0, 32'h30, 32'h66, 32'h0, 5'd6, 1'b1, 32'h00000777,
                    1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'hDEADBEEF};
        vecs[8] = '{3'b001, 2'b00, 1'b0, 32'h22, 32'h77, 32'h0, 5'd0, 1'b0, 32'h0,
                    1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'hDEADBEEF};
        vecs[9] = '{3'b010, 2'b11, 1'b0, 32'h8, 32'h0, 32'h0, 5'd31, 1'b1, 32'hCAFEF00D,
                    1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 32'hCAFEF00D};

        rst = 1'b1;
        drv(3'b000, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_wb_ctlwb", {30'd0, WB_ctlwb}, 32'd0);
        chk("rst_wb_alu", WB_alu_out, 32'd0);
        chk("rst_wb_rd", {27'd0, WB_rd}, 32'd0);
        chk("rst_wb_rdata", WB_read_data, 32'd0);
        chk("rst_fault", {31'd0, mem_fault}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        rst = 1'b0;

        // Single-cycle vectors, each starting from IDLE
        for (int i = 0; i < 10; i++) begin
            drv(vecs[i].ctlm, vecs[i].ctlwb, vecs[i].zero, vecs[i].addr, vecs[i].rd2,
                vecs[i].bpc, vecs[i].rd, vecs[i].ack, vecs[i].rdata);
            #1;
            chk("vec_req", {31'd0, dmem_req}, {31'd0, vecs[i].e_req});
            chk("vec_we", {31'd0, dmem_we}, {31'd0, vecs[i].e_we});
            chk("vec_stall", {31'd0, mem_stall}, 32'd0);
            chk("vec_pc_src", {31'd0, pc_src}, {31'd0, vecs[i].e_pc});
            chk("vec_target", branch_target, vecs[i].bpc);
            push(vecs[i].e_full, vecs[i].e_ctlwb, vecs[i].addr, vecs[i].rd, vecs[i].e_rdata);
            tick(vecs[i].e_fault);
        end
        exp_rdata = 32'hCAFEF00D;

        run_acc("st3", 3'b001, 2'b00, 32'h20, 32'h1234, 5'd0, 3, 32'h0);
        run_acc("ld2", 3'b010, 2'b11, 32'h44, 32'h0, 5'd9, 2, 32'h0BADCAFE);

        // Timeout: never acked in time; an ack in the abort cycle must be ignored
        for (int k = 0; k <= 8; k++) begin
            drv(3'b010, 2'b11, 1'b0, 32'h50, 32'h0, 32'h0, 5'd11, (k == 8), 32'h5555);
            #1;
            chk("to_req", {31'd0, dmem_req}, {31'd0, (k < 8)});
            chk("to_stall", {31'd0, mem_stall}, {31'd0, (k < 8)});
            push((k == 8), 2'b00, 32'h0, 5'd0, exp_rdata);
            if (k == 8) sbq[sbq.size()-1].full = 1'b0;
            tick(k == 8);
        end
        chk("to_rdata_held", WB_read_data, exp_rdata);
        drv(3'b010, 2'b11, 1'b0, 32'h60, 32'h0, 32'h0, 5'd10, 1'b1, 32'h6060);
        #1;
        chk("after_to_req", {31'd0, dmem_req}, 32'd1);
        chk("after_to_stall", {31'd0, mem_stall}, 32'd0);
        exp_rdata = 32'h6060;
        push(1'b1, 2'b11, 32'h60, 5'd10, exp_rdata);
        tick(1'b0);

        // Reset during the second WAIT cycle
        for (int k = 0; k <= 2; k++) begin
            drv(3'b010, 2'b11, 1'b0, 32'h70, 32'h0, 32'h0, 5'd12, 1'b0, 32'h0);
            if (k == 2) rst = 1'b1;
            #1;
            chk("rw_req", {31'd0, dmem_req}, 32'd1);
            if (k < 2) push(1'b0, 2'b00, 32'h0, 5'd0, 32'h0);
            else push(1'b1, 2'b00, 32'h0, 5'd0, 32'h0);
            tick(1'b0);
        end
        rst = 1'b0;
        exp_rdata = 32'h0;
        drv(3'b010, 2'b11, 1'b0, 32'h71, 32'h0, 32'h0, 5'd13, 1'b1, 32'h9999);
        #1;
        chk("post_rst_req", {31'd0, dmem_req}, 32'd0);
        chk("post_rst_stall", {31'd0, mem_stall}, 32'd0);
        push(1'b0, 2'b00, 32'h0, 5'd0, 32'h0);
        tick(1'b1);
        chk("post_rst_rdata", WB_read_data, 32'h0);

        drv(3'b000, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        tick(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
